cpu_decode_queue: RTL and testbench
===================================

# cpu_decode_queue

Parametrised decode-and-buffer stage between fetch and issue. Accepts up to WIDTH fetched instructions per cycle and decodes each lane into MIPS-I class flags and register indices. Optionally squashes instructions that can be safely ignored, and stores the results in a DEPTH-entry circular queue. Issue drains one decoded instruction per cycle through a valid/ready handshake.

## Interface
- WIDTH, 2, fetch lanes per cycle (1..4)
- DEPTH, 8, queue entries; power of two, at least 2*WIDTH
- DROP_NOP, 1, 1 = do not enqueue nop-class instructions; 0 = enqueue everything
- clk  in  1  clock; reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard queue contents (pipeline redirect)
- in_valid  in  1  fetch lanes valid
- in_ready  out  1  at least WIDTH free entries
- in_count  in  clog2(WIDTH)+1  number of valid lanes, 1..WIDTH, lane 0 upward
- in_inst  in  32*WIDTH  lane k at [32k+31:32k]
- in_pc  in  32*WIDTH  PC per lane, same packing
- out_valid  out  1  head entry valid
- out_ready  in  1  issue accepts head
- out_inst, out_pc  out  32 each  head instruction and PC
- out_rr1, out_rr2, out_rw  out  5 each  read port 1, read port 2, write register (0 = none)
- out_class  out  10  {could_branch, has_imm, exception, cp0, branch, mul, shift, alu, store, load}, load = bit 0
- nop_drops  out  16  saturating count of squashed instructions

## Operation
- Decode is combinational per lane. Field positions: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Class rules:
  - load: op[5:3]=100
  - store: op[5:3]=101
  - alu: R-form (op=0, funct[5:4]=10) or I-form (op[5:3]=001)
  - shift: op=0, funct[5:3]=000
  - mul: op=0, funct[5:4]=01
  - branch: op=0 with funct[5:1]=00100, or op[5:1]=00001, or op=000001, or op[5:2]=0001
  - cp0: op=010000
  - exception: op=0, funct[5:1]=00110
- has_imm = load|store|alu I-form|op=000001|op[5:2]=0001.
- could_branch = load|store|branch|exception|cp0|ADD (op 0, funct 100000)|SUB (funct 100010)|ADDI (op 001000).
- nop = !could_branch & ((alu R-form|shift) & rd=0 | alu I-form & rt=0).
- out_rw: first matching rule applies.
  - 0 for J (000010) or store
  - 31 for JAL (000011), or for op=000001 with rt=10000/10001
  - 0 for other branches
  - rt for load or alu I-form
  - otherwise rd
- out_rr1 = 0 for J, JAL or exception; otherwise rs.
- out_rr2 = 0 if has_imm, J or JAL; otherwise rt.
- Enqueue occurs when in_valid & in_ready. Lanes 0..in_count-1 are taken.
  - With DROP_NOP=1, nop lanes are skipped. Surviving lanes are compacted in lane order into consecutive entries from the write pointer.
  - Each skipped lane adds 1 to nop_drops, saturating at 16'hFFFF.
- in_ready = (DEPTH - occupancy) >= WIDTH. It depends only on registered state, never on in_count or in_valid.
- Dequeue occurs when out_valid & out_ready. The read pointer advances by 1.
- Occupancy update: occupancy' = occupancy + written - popped. Simultaneous enqueue and dequeue are legal at any occupancy.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits so that full and empty are distinguishable.
- flush has priority over enqueue and dequeue in the same cycle:
  - next cycle: occupancy, write pointer and read pointer are 0, out_valid is 0, in_ready is 1
  - the same-cycle enqueue is discarded and does not increment nop_drops
- When out_valid=0, all out_* data ports drive 0.
- in_count=0 or in_count>WIDTH with in_valid=1 is illegal input. Behaviour is unspecified; the bench asserts it never occurs.

## Timing
- Reset (rst_n=0 at a clk edge) gives: occupancy 0, pointers 0, out_valid 0, out_* 0, in_ready 1, nop_drops 0. This also applies to reset asserted mid-operation.
- nop_drops is cleared only by reset, not by flush.
- Enqueue at edge N makes the entry visible on out_* after edge N. There is no same-cycle bypass from in_* to out_*.
- out_* is a registered read of the head entry. It stays stable while out_valid & !out_ready.
- Full throughput is one dequeue per cycle and up to WIDTH enqueues per cycle, with no bubbles between back-to-back pops.
- in_ready deasserts the cycle after occupancy exceeds DEPTH-WIDTH. It reasserts the cycle after a pop brings occupancy to DEPTH-WIDTH or below.

## Test plan
- Reset, then WIDTH=2 lanes {0x8C430004 lw, 0xAC430008 sw}, then out_ready=1:
  - first pop: class bit0=1, rw=3, rr1=2, rr2=0
  - second pop: bit1=1, rw=0, rr2=0
- DROP_NOP=1 with lanes {0x00000000, 0x24020005 addiu}:
  - only the addiu is enqueued, with rw=2
  - nop_drops=1
  - the same input with DROP_NOP=0 enqueues 2 entries
- Fill with out_ready=0:
  - in_ready falls at occupancy 7 (DEPTH=8, WIDTH=2)
  - then enqueue and dequeue in the same cycle: occupancy holds and the pointers wrap past 7→0 with order preserved
- JAL 0x0C000010 → rw=31, rr1=0. BGEZAL 0x04510003 → rw=31, has_imm=1, rr2=0. SYSCALL 0x0000000C → exception=1, rr1=0.
- flush asserted together with in_valid and out_ready at occupancy 5:
  - next cycle: out_valid=0, in_ready=1, nop_drops unchanged, out_* all 0
- rst_n low mid-stream for 1 cycle → every output at its reset value on the next cycle; normal enqueue resumes after.

Source files
------------

// File: rtl/cpu_decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for cpu_decode_queue.
// The slave modport is the queue; the master modport is the fetch/issue environment.
interface cpu_decode_queue_if #(
    parameter int WIDTH = 2
) ();
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [CNT_W-1:0]       in_count;
    logic [32*WIDTH-1:0]    in_inst;
    logic [32*WIDTH-1:0]    in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_inst;
    logic [31:0]            out_pc;
    logic [4:0]             out_rr1;
    logic [4:0]             out_rr2;
    logic [4:0]             out_rw;
    logic [9:0]             out_class;
    logic [15:0]            nop_drops;

    modport master (
        output in_valid, in_count, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_rr1, out_rr2, out_rw,
               out_class, nop_drops
    );

    modport slave (
        input  in_valid, in_count, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_rr1, out_rr2, out_rw,
               out_class, nop_drops
    );
endinterface

// File: rtl/cpu_decode_queue.sv
// Decode-and-buffer stage: decodes up to WIDTH MIPS-I instructions per cycle into
// class flags and register indices, optionally squashes nops, and queues them for issue.
module cpu_decode_queue #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 8,
    parameter int DROP_NOP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    cpu_decode_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    typedef struct packed {
        logic [4:0] rr1;
        logic [4:0] rr2;
        logic [4:0] rw;
        logic [9:0] cls;
        logic       nop;
    } dec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  rw;
        logic [9:0]  cls;
    } entry_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [5:0] funct);
        dec_t d;
        logic r_form, load, store, alu_r, alu_i, shift, mul, regimm, j_op, jal_op;
        logic branch, cp0, exc, has_imm, could_branch;
        r_form  = (op == 6'b000000);
        load    = (op[5:3] == 3'b100);
        store   = (op[5:3] == 3'b101);
        alu_r   = r_form && (funct[5:4] == 2'b10);
        alu_i   = (op[5:3] == 3'b001);
        shift   = r_form && (funct[5:3] == 3'b000);
        mul     = r_form && (funct[5:4] == 2'b01);
        regimm  = (op == 6'b000001);
        j_op    = (op == 6'b000010);
        jal_op  = (op == 6'b000011);
        branch  = (r_form && (funct[5:1] == 5'b00100)) || (op[5:1] == 5'b00001) ||
                  regimm || (op[5:2] == 4'b0001);
        cp0     = (op == 6'b010000);
        exc     = r_form && (funct[5:1] == 5'b00110);
        has_imm = load || store || alu_i || regimm || (op[5:2] == 4'b0001);
        could_branch = load || store || branch || exc || cp0 ||
                       (r_form && (funct == 6'b100000)) ||
                       (r_form && (funct == 6'b100010)) || (op == 6'b001000);
        d.nop = !could_branch && ((((alu_r || shift) && (rd == 5'd0))) ||
                                  (alu_i && (rt == 5'd0)));
        d.cls = {could_branch, has_imm, exc, cp0, branch, mul, shift, alu_r || alu_i,
                 store, load};
        d.rr1 = (j_op || jal_op || exc) ? 5'd0 : rs;
        d.rr2 = (has_imm || j_op || jal_op) ? 5'd0 : rt;
        // Link writes (JAL, BLTZAL/BGEZAL) must be resolved before the generic branch rule.
        if (j_op || store) begin
            d.rw = 5'd0;
        end else if (jal_op || (regimm && (rt[4:1] == 4'b1000))) begin
            d.rw = 5'd31;
        end else if (branch) begin
            d.rw = 5'd0;
        end else if (load || alu_i) begin
            d.rw = rt;
        end else begin
            d.rw = rd;
        end
        return d;
    endfunction

    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    occ_t        occ_q, occ_d;
    logic [15:0] nop_drops_q, nop_drops_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    entry_t      out_q, out_d;

    logic        push_s, pop_s, lane_take_s, lane_skip_s;
    occ_t        written_s, skipped_s;
    ptr_t        widx_s;
    logic [31:0] lane_inst_s;
    dec_t        lane_dec_s;
    logic [16:0] drop_sum_s;

    // Next-state of queue storage, pointers, occupancy, drop counter and registered head view.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        nop_drops_d = nop_drops_q;
        written_s   = '0;
        skipped_s   = '0;
        widx_s      = '0;
        lane_inst_s = '0;
        lane_dec_s  = '0;
        lane_take_s = 1'b0;
        lane_skip_s = 1'b0;
        drop_sum_s  = '0;
        push_s      = bus.in_valid & in_ready_q;
        pop_s       = out_valid_q & bus.out_ready;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_s) begin
                // Surviving lanes are packed back-to-back starting at the write pointer.
                for (int k = 0; k < WIDTH; k++) begin
                    lane_inst_s = bus.in_inst[32*k +: 32];
                    lane_dec_s  = decode(lane_inst_s[31:26], lane_inst_s[25:21],
                                         lane_inst_s[20:16], lane_inst_s[15:11],
                                         lane_inst_s[5:0]);
                    lane_skip_s = (k < int'(bus.in_count)) && (DROP_NOP != 0) && lane_dec_s.nop;
                    lane_take_s = (k < int'(bus.in_count)) && !lane_skip_s;
                    widx_s      = wr_ptr_q + written_s[PTR_W-1:0];
                    if (lane_take_s) begin
                        mem_d[widx_s].inst = lane_inst_s;
                        mem_d[widx_s].pc   = bus.in_pc[32*k +: 32];
                        mem_d[widx_s].rr1  = lane_dec_s.rr1;
                        mem_d[widx_s].rr2  = lane_dec_s.rr2;
                        mem_d[widx_s].rw   = lane_dec_s.rw;
                        mem_d[widx_s].cls  = lane_dec_s.cls;
                    end else begin
                        mem_d[widx_s] = mem_d[widx_s];
                    end
                    written_s = written_s + occ_t'(lane_take_s);
                    skipped_s = skipped_s + occ_t'(lane_skip_s);
                end
            end else begin
                written_s = '0;
            end
            wr_ptr_d    = wr_ptr_q + written_s[PTR_W-1:0];
            rd_ptr_d    = rd_ptr_q + ptr_t'(pop_s);
            occ_d       = occ_q + written_s - occ_t'(pop_s);
            drop_sum_s  = {1'b0, nop_drops_q} + 17'(skipped_s);
            nop_drops_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
        out_valid_d = (occ_d != '0);
        if (out_valid_d) begin
            out_d = mem_d[rd_ptr_d];
        end else begin
            out_d = '0;
        end
        in_ready_d = ((occ_t'(DEPTH) - occ_d) >= occ_t'(WIDTH));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            nop_drops_q <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            nop_drops_q <= nop_drops_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_rr1   = out_q.rr1;
    assign bus.out_rr2   = out_q.rr2;
    assign bus.out_rw    = out_q.rw;
    assign bus.out_class = out_q.cls;
    assign bus.nop_drops = nop_drops_q;
endmodule

// File: tb/tb_cpu_decode_queue.sv
// Directed bench for cpu_decode_queue: two instances (DROP_NOP=1 and DROP_NOP=0) driven
// with identical stimulus; expectations are hand-decoded constants.
module tb_cpu_decode_queue;
    localparam int WIDTH = 2;
    localparam int DEPTH = 8;

    localparam logic [31:0] LW     = 32'h8C43_0004;
    localparam logic [31:0] SW     = 32'hAC43_0008;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] ADDIU  = 32'h2402_0005;
    localparam logic [31:0] JAL    = 32'h0C00_0010;
    localparam logic [31:0] BGEZAL = 32'h0451_0003;
    localparam logic [31:0] SYSC   = 32'h0000_000C;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    cpu_decode_queue_if #(.WIDTH(WIDTH)) q1 ();
    cpu_decode_queue_if #(.WIDTH(WIDTH)) q0 ();

    cpu_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_NOP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(q1.slave)
    );
    cpu_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_NOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(q0.slave)
    );

    always #5 clk = ~clk;

    // Fetch must never present an empty or oversized lane group.
    always @(posedge clk) begin
        if (rst_n && q1.in_valid) begin
            assert (q1.in_count >= 2'd1 && q1.in_count <= 2'd2)
            else $error("FAIL in_count_legal: observed %0d required 1..2", q1.in_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] cnt, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] p0, input logic [31:0] p1);
        q1.in_valid = v; q1.in_count = cnt; q1.in_inst = {i1, i0}; q1.in_pc = {p1, p0};
        q0.in_valid = v; q0.in_count = cnt; q0.in_inst = {i1, i0}; q0.in_pc = {p1, p0};
    endtask

    task automatic set_ready(input logic r);
        q1.out_ready = r;
        q0.out_ready = r;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int n);
        return 32'h2401_0000 + 32'(n);
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_ready(1'b0);
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(q1.out_valid), 64'h0);
        chk("rst_in_ready", 64'(q1.in_ready), 64'h1);
        chk("rst_nop_drops", 64'(q1.nop_drops), 64'h0);
        chk("rst_out_data", {q1.out_inst, q1.out_pc}, 64'h0);
        chk("rst_out_fields", 64'({q1.out_rr1, q1.out_rr2, q1.out_rw, q1.out_class}), 64'h0);

        // lw / sw pair
        drive(1'b1, 2'd2, LW, SW, 32'h100, 32'h104);
        tick();
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("lw_valid", 64'(q1.out_valid), 64'h1);
        chk("lw_inst_pc", {q1.out_inst, q1.out_pc}, {LW, 32'h100});
        chk("lw_class", 64'(q1.out_class), 64'h301);
        chk("lw_regs", 64'({q1.out_rw, q1.out_rr1, q1.out_rr2}), 64'({5'd3, 5'd2, 5'd0}));
        set_ready(1'b1);
        tick();
        chk("sw_inst_pc", {q1.out_inst, q1.out_pc}, {SW, 32'h104});
        chk("sw_class", 64'(q1.out_class), 64'h302);
        chk("sw_regs", 64'({q1.out_rw, q1.out_rr1, q1.out_rr2}), 64'({5'd0, 5'd2, 5'd0}));
        tick();
        chk("lwsw_drained", 64'(q1.out_valid), 64'h0);
        chk("empty_out_data", {q1.out_inst, q1.out_pc}, 64'h0);
        set_ready(1'b0);

        // nop squashing
        drive(1'b1, 2'd2, NOP, ADDIU, 32'h200, 32'h204);
        tick();
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("drop_head", {q1.out_inst, q1.out_pc}, {ADDIU, 32'h204});
        chk("drop_addiu_rw", 64'(q1.out_rw), 64'd2);
        chk("drop_addiu_class", 64'(q1.out_class), 64'h104);
        chk("drop_count", 64'(q1.nop_drops), 64'd1);
        chk("keep_valid", 64'(q0.out_valid), 64'h1);
        chk("keep_head", {q0.out_inst, q0.out_pc}, {NOP, 32'h200});
        chk("keep_nop_fields", 64'({q0.out_rr1, q0.out_rr2, q0.out_rw, q0.out_class}), 64'h008);
        chk("keep_count", 64'(q0.nop_drops), 64'd0);
        chk("keep_ready", 64'(q0.in_ready), 64'h1);
        set_ready(1'b1);
        tick();
        chk("drop_one_entry", 64'(q1.out_valid), 64'h0);
        chk("keep_second", 64'(q0.out_inst), 64'(ADDIU));
        tick();
        chk("keep_two_entries", 64'(q0.out_valid), 64'h0);
        set_ready(1'b0);

        // fill, backpressure, and wrap with simultaneous push/pop
        drive(1'b1, 2'd2, mk(1), mk(2), 32'h0, 32'h0); tick();
        drive(1'b1, 2'd2, mk(3), mk(4), 32'h0, 32'h0); tick();
        drive(1'b1, 2'd2, mk(5), mk(6), 32'h0, 32'h0); tick();
        chk("ready_at_occ6", 64'(q1.in_ready), 64'h1);
        drive(1'b1, 2'd1, mk(7), mk(99), 32'h0, 32'h0); tick();
        chk("ready_at_occ7", 64'(q1.in_ready), 64'h0);
        chk("full_head", 64'(q1.out_inst), 64'(mk(1)));
        drive(1'b1, 2'd2, mk(97), mk(98), 32'h0, 32'h0); tick();
        chk("blocked_ready", 64'(q1.in_ready), 64'h0);
        chk("blocked_head_stable", 64'(q1.out_inst), 64'(mk(1)));
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_ready(1'b1);
        tick();
        chk("ready_back_occ6", 64'(q1.in_ready), 64'h1);
        chk("pop_head2", 64'(q1.out_inst), 64'(mk(2)));
        drive(1'b1, 2'd1, mk(8), 32'h0, 32'h0, 32'h0); tick();
        chk("pushpop_ready", 64'(q1.in_ready), 64'h1);
        chk("pushpop_head3", 64'(q1.out_inst), 64'(mk(3)));
        drive(1'b1, 2'd1, mk(9), 32'h0, 32'h0, 32'h0); tick();
        chk("pushpop2_ready", 64'(q1.in_ready), 64'h1);
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int n = 4; n <= 9; n++) begin
            chk("drain_order", 64'(q1.out_inst), 64'(mk(n)));
            tick();
        end
        chk("drain_empty", 64'(q1.out_valid), 64'h0);
        set_ready(1'b0);

        // jump/link/exception decode
        drive(1'b1, 2'd2, JAL, BGEZAL, 32'h300, 32'h304); tick();
        drive(1'b1, 2'd1, SYSC, 32'h0, 32'h308, 32'h0); tick();
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("jal_regs", 64'({q1.out_rw, q1.out_rr1, q1.out_rr2}), 64'({5'd31, 5'd0, 5'd0}));
        chk("jal_class", 64'(q1.out_class), 64'h220);
        set_ready(1'b1);
        tick();
        chk("bgezal_regs", 64'({q1.out_rw, q1.out_rr1, q1.out_rr2}), 64'({5'd31, 5'd2, 5'd0}));
        chk("bgezal_class", 64'(q1.out_class), 64'h320);
        tick();
        chk("syscall_regs", 64'({q1.out_rw, q1.out_rr1, q1.out_rr2}), 64'h0);
        chk("syscall_class", 64'(q1.out_class), 64'h280);
        tick();
        chk("special_drained", 64'(q1.out_valid), 64'h0);
        set_ready(1'b0);

        // flush at occupancy 5 with concurrent push and pop
        drive(1'b1, 2'd2, mk(10), mk(11), 32'h0, 32'h0); tick();
        drive(1'b1, 2'd2, mk(12), mk(13), 32'h0, 32'h0); tick();
        drive(1'b1, 2'd1, mk(14), 32'h0, 32'h0, 32'h0); tick();
        chk("preflush_head", 64'(q1.out_inst), 64'(mk(10)));
        drive(1'b1, 2'd2, NOP, mk(15), 32'h0, 32'h0);
        set_ready(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_ready(1'b0);
        chk("flush_out_valid", 64'(q1.out_valid), 64'h0);
        chk("flush_in_ready", 64'(q1.in_ready), 64'h1);
        chk("flush_nop_drops", 64'(q1.nop_drops), 64'd1);
        chk("flush_out_data", {q1.out_inst, q1.out_pc}, 64'h0);
        chk("flush_out_fields", 64'({q1.out_rr1, q1.out_rr2, q1.out_rw, q1.out_class}), 64'h0);
        drive(1'b1, 2'd1, mk(20), 32'h0, 32'h0, 32'h0); tick();
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("postflush_head", 64'({q1.out_valid, q1.out_inst}), 64'({1'b1, mk(20)}));

        // reset mid-stream
        drive(1'b1, 2'd2, NOP, mk(21), 32'h0, 32'h0); tick();
        chk("prerst_drops", 64'(q1.nop_drops), 64'd2);
        rst_n = 1'b0;
        drive(1'b1, 2'd2, mk(22), mk(23), 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("midrst_out_valid", 64'(q1.out_valid), 64'h0);
        chk("midrst_in_ready", 64'(q1.in_ready), 64'h1);
        chk("midrst_nop_drops", 64'(q1.nop_drops), 64'h0);
        chk("midrst_out_data", {q1.out_inst, q1.out_pc}, 64'h0);
        drive(1'b1, 2'd2, mk(30), mk(31), 32'h0, 32'h0); tick();
        drive(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("resume_head", 64'({q1.out_valid, q1.out_inst}), 64'({1'b1, mk(30)}));
        set_ready(1'b1);
        tick();
        chk("resume_second", 64'(q1.out_inst), 64'(mk(31)));
        tick();
        chk("resume_drained", 64'(q1.out_valid), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
